// File: rtl/onehot_encoder_register.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_register
//  Description : Registered one-hot to binary encoder with valid/ready
//                handshake, a 2-entry skid buffer for full throughput with a
//                registered in_ready, and a saturating malformed-input counter.
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_encoder_register #(
    parameter int INPUT_WIDTH   = 16,
    parameter int OUTPUT_WIDTH  = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INPUT_WIDTH-1:0]   onehot_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUTPUT_WIDTH-1:0]  binary_out,
    output logic                     out_error,
    input  logic                     err_clear,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_MAX = '1;

    // The index width must exactly cover the one-hot width.
    if (INPUT_WIDTH != (1 << OUTPUT_WIDTH)) begin : g_width_check
        $error("onehot_encoder_register: INPUT_WIDTH must equal 2**OUTPUT_WIDTH");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // main empty, skid empty
        S_ONE   = 2'd1,   // main full,  skid empty
        S_FULL  = 2'd2    // main full,  skid full
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_load_main_enc;
    logic                    w_load_main_skid;
    logic                    w_load_skid;

    logic [OUTPUT_WIDTH-1:0] r_skid_idx;
    logic                    r_skid_err;

    logic [OUTPUT_WIDTH-1:0] w_enc_idx;
    logic                    w_enc_err;
    logic                    w_in_xfer;
    logic                    w_out_xfer;

    assign w_in_xfer  = in_valid  && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Encode: lowest set bit wins; malformed when zero or multiple bits set.
    always_comb begin
        w_enc_idx = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (onehot_in[i]) begin
                w_enc_idx = OUTPUT_WIDTH'(i);
            end
        end
        w_enc_err = (onehot_in == '0) ||
                    ((onehot_in & (onehot_in - INPUT_WIDTH'(1))) != '0);
    end

    // Buffer next-state and register load selects.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_enc  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_next_state    = S_ONE;
                    w_load_main_enc = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main_enc = 1'b1;
                end else if (w_in_xfer) begin
                    w_next_state = S_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_out_xfer) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_xfer) begin
                    w_next_state     = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            in_ready  <= (w_next_state != S_FULL);
            out_valid <= (w_next_state != S_EMPTY);
        end
    end

    // Main (output) and skid data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary_out <= '0;
            out_error  <= 1'b0;
            r_skid_idx <= '0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_load_main_enc) begin
                binary_out <= w_enc_idx;
                out_error  <= w_enc_err;
            end else if (w_load_main_skid) begin
                binary_out <= r_skid_idx;
                out_error  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_idx <= w_enc_idx;
                r_skid_err <= w_enc_err;
            end
        end
    end

    // Saturating count of accepted malformed beats; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= (w_in_xfer && w_enc_err) ? ERR_CNT_WIDTH'(1) : '0;
        end else if (w_in_xfer && w_enc_err && (err_count != C_ERR_MAX)) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_encoder_register
//  Description : Self-checking bench for onehot_encoder_register using a
//                scoreboard queue of expected {error, index} beats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_onehot_encoder_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] onehot_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  binary_out;
    logic        out_error;
    logic        err_clear;
    logic [7:0]  err_count;

    // Second instance with a narrow counter to exercise saturation.
    logic        in_ready2;
    logic        out_valid2;
    logic [3:0]  binary_out2;
    logic        out_error2;
    logic [1:0]  err_count2;

    int total = 0;
    int fails = 0;
    int beats_out = 0;
    int cnt1 = 0;
    int cnt2 = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    onehot_encoder_register #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(4), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .onehot_in(onehot_in), .out_valid(out_valid), .out_ready(out_ready),
        .binary_out(binary_out), .out_error(out_error),
        .err_clear(err_clear), .err_count(err_count)
    );

    onehot_encoder_register #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(4), .ERR_CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .onehot_in(onehot_in), .out_valid(out_valid2), .out_ready(out_ready),
        .binary_out(binary_out2), .out_error(out_error2),
        .err_clear(err_clear), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encode: {err, lowest set index}.
    function automatic logic [4:0] ref_enc(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
                break;
            end
        end
        return {($countones(v) != 1), idx};
    endfunction

    // One clock: check handshake flags, score transfers, advance, check counters.
    task automatic tick();
        logic       ix;
        logic       ox;
        logic [4:0] e;
        logic       err_in;
        chk("in_ready",   in_ready,   sb_q.size() < 2);
        chk("out_valid",  out_valid,  sb_q.size() != 0);
        chk("in_ready2",  in_ready2,  sb_q.size() < 2);
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        if (ox) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("binary_out", binary_out, e[3:0]);
                chk("out_error",  out_error,  e[4]);
                chk("binary_out2", binary_out2, e[3:0]);
                beats_out++;
            end
        end
        err_in = 1'b0;
        if (ix) begin
            e = ref_enc(onehot_in);
            sb_q.push_back(e);
            err_in = e[4];
        end
        if (err_clear) begin
            cnt1 = err_in ? 1 : 0;
            cnt2 = err_in ? 1 : 0;
        end else if (err_in) begin
            if (cnt1 < 255) cnt1++;
            if (cnt2 < 3)   cnt2++;
        end
        @(posedge clk);
        #1;
        chk("err_count",  err_count,  cnt1);
        chk("err_count2", err_count2, cnt2);
    endtask

    task automatic send(input logic [15:0] v);
        int guard;
        in_valid  = 1'b1;
        onehot_in = v;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int cycles;
        int beats_in;
        rst = 1'b1; in_valid = 1'b0; onehot_in = '0; out_ready = 1'b0; err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_binary_out", binary_out, 0);
        chk("rst_out_error",  out_error,  0);
        chk("rst_err_count",  err_count,  0);
        rst = 1'b0;
        tick();

        // Sweep of single-bit inputs at full rate.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            onehot_in = 16'(1) << k;
            chk("sweep_full_rate", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("sweep_err_count", err_count, 0);

        // Malformed inputs.
        send(16'h0000);
        chk("zero_err_count", err_count, 1);
        send(16'h0024);
        chk("multi_err_count", err_count, 2);
        drain();

        // Backpressure: third beat must wait for space.
        out_ready = 1'b0;
        send(16'h0002);
        send(16'h0008);
        chk("bp_in_ready_low", in_ready, 0);
        in_valid  = 1'b1;
        onehot_in = 16'h0010;
        tick();
        chk("bp_third_waits", sb_q.size(), 2);
        out_ready = 1'b1;
        send(16'h0010);
        drain();

        // Randomised handshake against the scoreboard.
        beats_in  = 0;
        beats_out = 0;
        cycles    = 0;
        while ((beats_out < 10000) && (cycles < 60000)) begin
            in_valid  = (beats_in < 10000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            case ($urandom_range(7))
                0:       onehot_in = 16'($urandom);
                1:       onehot_in = 16'h0000;
                default: onehot_in = 16'(1) << $urandom_range(15);
            endcase
            if (in_valid && in_ready) beats_in++;
            tick();
            cycles++;
        end
        chk("random_complete", beats_out, 10000);
        drain();

        // Narrow counter saturation and clear priority.
        out_ready = 1'b1;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        for (int n = 0; n < 5; n++) send(16'h0003);
        chk("sat_err_count2", err_count2, 3);
        in_valid  = 1'b1;
        onehot_in = 16'h0000;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        in_valid  = 1'b0;
        chk("clear_with_err", err_count2, 1);
        drain();

        // Reset while full discards buffered beats.
        out_ready = 1'b0;
        send(16'h0000);
        send(16'h0040);
        chk("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        #2;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready",  in_ready,  1);
        chk("arst_err_count", err_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        cnt1 = 0;
        cnt2 = 0;
        send(16'h0400);
        chk("post_rst_binary", binary_out, 10);
        drain();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire
